// File: rtl/sr_cmd_arbiter.sv
// sr_cmd_arbiter: round-robin arbiter that serialises SET/CLEAR commands from
// several requesters onto an external SR flip-flop bank. Each pulse is
// read back from the bank one cycle later and checked.
module sr_cmd_arbiter #(
    parameter int N_REQ  = 4,
    parameter int N_FLAG = 8,
    parameter int IW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_op,
    input  logic [IW*N_REQ-1:0]  req_idx,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_FLAG-1:0]    s_out,
    output logic [N_FLAG-1:0]    r_out,
    input  logic [N_FLAG-1:0]    q_fb,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 err_illegal,
    output logic                 err_mismatch
);

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpClear = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpIll   = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StCheck = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          grant_q, grant_d;
    logic [1:0]          op_q, op_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_FLAG-1:0]   s_q, s_d;
    logic [N_FLAG-1:0]   r_q, r_d;
    logic                ill_q, ill_d;

    logic                win_found;
    logic [2:0]          win_id;
    int unsigned         cand;
    logic [1:0]          win_op;
    logic [IW-1:0]       win_idx;
    logic                idx_ok;
    logic                ready_en;
    logic                q_sel;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = 3'(cand);
            end
        end
    end

    // Pick out the winner's opcode and index and range-check the index.
    always_comb begin
        win_op  = req_op[2*int'(win_id) +: 2];
        win_idx = req_idx[IW*int'(win_id) +: IW];
        idx_ok  = (int'(win_idx) < N_FLAG);
    end

    // Ready is combinational in IDLE; gated by rst so it drops at once in reset.
    always_comb begin
        ready_en = (state_q == StIdle) && win_found && rst;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready[k] = ready_en && (win_id == 3'(k));
        end
    end

    // Next-state logic; s/r drive defaults to zero so every pulse lasts one cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        op_d     = op_q;
        idx_d    = idx_q;
        s_d      = '0;
        r_d      = '0;
        ill_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d  = win_id;
                    rr_ptr_d = 3'((int'(win_id) + 1) % N_REQ);
                    op_d     = win_op;
                    idx_d    = win_idx;
                    if (win_op == OpIll || !idx_ok) begin
                        ill_d = 1'b1;
                    end else if (win_op == OpSet || win_op == OpClear) begin
                        state_d = StIssue;
                        for (int f = 0; f < N_FLAG; f++) begin
                            s_d[f] = (win_op == OpSet) && (int'(win_idx) == f);
                            r_d[f] = (win_op == OpClear) && (int'(win_idx) == f);
                        end
                    end
                end
            end
            StIssue: state_d = StCheck;
            StCheck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= 3'd0;
            grant_q  <= 3'd0;
            op_q     <= OpNop;
            idx_q    <= '0;
            s_q      <= '0;
            r_q      <= '0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            s_q      <= s_d;
            r_q      <= r_d;
            ill_q    <= ill_d;
        end
    end

    // Readback select: the stored index is always in range once in CHECK.
    always_comb begin
        q_sel = 1'b0;
        for (int f = 0; f < N_FLAG; f++) begin
            if (int'(idx_q) == f) begin
                q_sel = q_fb[f];
            end
        end
    end

    // Mismatch flags during the single CHECK cycle; expected level is 1 for SET.
    always_comb begin
        err_mismatch = (state_q == StCheck) && (q_sel != (op_q == OpSet));
        busy         = (state_q != StIdle);
        grant_id     = grant_q;
        s_out        = s_q;
        r_out        = r_q;
        err_illegal  = ill_q;
    end

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Randomised scoreboard bench for sr_cmd_arbiter with a behavioural SR flop bank.
module tb_sr_cmd_arbiter;

    localparam int NR = 4;
    localparam int NF = 8;
    localparam int IW = 4;
    // Bit 3 stuck high, bit 2 stuck low: CLEAR 3 / SET 2 must read back wrong.
    localparam logic [NF-1:0] STUCK_MASK = 8'h0C;
    localparam logic [NF-1:0] STUCK_VAL  = 8'h08;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [2*NR-1:0]   req_op;
    logic [IW*NR-1:0]  req_idx;
    logic [NR-1:0]     req_ready;
    logic [NF-1:0]     s_out, r_out, q_fb;
    logic              busy;
    logic [2:0]        grant_id;
    logic              err_illegal, err_mismatch;

    sr_cmd_arbiter #(.N_REQ(NR), .N_FLAG(NF), .IW(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_idx      (req_idx),
        .req_ready    (req_ready),
        .s_out        (s_out),
        .r_out        (r_out),
        .q_fb         (q_fb),
        .busy         (busy),
        .grant_id     (grant_id),
        .err_illegal  (err_illegal),
        .err_mismatch (err_mismatch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External SR flop bank, not touched by rst.
    logic [NF-1:0] bank = '0;
    always @(posedge clk) bank <= (bank | s_out) & ~r_out;
    assign q_fb = (bank & ~STUCK_MASK) | (STUCK_VAL & STUCK_MASK);

    typedef struct {
        int          cyc;
        logic [NF-1:0] s;
        logic [NF-1:0] r;
        logic        ill;
        logic        mis;
        logic        busy;
        logic [2:0]  grant;
    } exp_t;
    exp_t expq[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    // Predictor: decides the expected winner and pushes timed expectations.
    int rr_m = 0, free_cyc = 0, hs_w = -1;
    int pw, pop, pix, pk;
    logic [NR-1:0] exp_ready;
    exp_t e1, e2;
    always @(negedge clk) begin
        exp_ready = '0;
        pw = -1;
        if (!rst) begin
            rr_m = 0;
            free_cyc = 0;
            expq.delete();
        end else if (cyc >= free_cyc) begin
            for (int k = 0; k < NR; k++) begin
                pk = (rr_m + k) % NR;
                if (pw < 0 && req_valid[pk]) pw = pk;
            end
        end
        if (pw >= 0) exp_ready[pw] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        hs_w = pw;
        if (pw >= 0) begin
            pop = int'(req_op[2*pw +: 2]);
            pix = int'(req_idx[IW*pw +: IW]);
            rr_m = (pw + 1) % NR;
            e1.cyc = cyc + 1; e1.s = '0; e1.r = '0; e1.ill = 1'b0; e1.mis = 1'b0;
            e1.busy = 1'b0; e1.grant = 3'(pw);
            if (pop == 3 || pix >= NF) begin
                e1.ill = 1'b1;
                expq.push_back(e1);
                free_cyc = cyc + 1;
            end else if (pop == 0) begin
                expq.push_back(e1);
                free_cyc = cyc + 1;
            end else begin
                if (pop == 2) e1.s[pix] = 1'b1;
                else          e1.r[pix] = 1'b1;
                e1.busy = 1'b1;
                expq.push_back(e1);
                e2 = e1;
                e2.cyc = cyc + 2; e2.s = '0; e2.r = '0;
                e2.mis = STUCK_MASK[pix] && (STUCK_VAL[pix] != (pop == 2));
                expq.push_back(e2);
                free_cyc = cyc + 3;
            end
        end
    end

    // Monitor: pops the expectation due this cycle and compares all outputs.
    logic [2:0] held_g = 3'd0;
    exp_t me;
    always @(negedge clk) begin
        me.cyc = cyc; me.s = '0; me.r = '0; me.ill = 1'b0; me.mis = 1'b0;
        me.busy = 1'b0; me.grant = held_g;
        if (!rst) begin
            held_g = 3'd0;
            me.grant = 3'd0;
        end else if (expq.size() > 0 && expq[0].cyc == cyc) begin
            me = expq.pop_front();
            held_g = me.grant;
        end
        chk("s_out", 32'(s_out), 32'(me.s));
        chk("r_out", 32'(r_out), 32'(me.r));
        chk("s_and_r", 32'(s_out & r_out), 32'(0));
        chk("err_illegal", 32'(err_illegal), 32'(me.ill));
        chk("err_mismatch", 32'(err_mismatch), 32'(me.mis));
        chk("busy", 32'(busy), 32'(me.busy));
        chk("grant_id", 32'(grant_id), 32'(me.grant));
    end

    task automatic set_cmd(input int i, input logic [1:0] op, input int ix);
        req_op[2*i +: 2]   = op;
        req_idx[IW*i +: IW] = IW'(ix);
        req_valid[i]       = 1'b1;
    endtask

    task automatic new_cmd(input int i);
        int r;
        logic [1:0] op;
        int ix;
        r = $urandom_range(99, 0);
        op = (r < 35) ? 2'b10 : (r < 70) ? 2'b01 : (r < 85) ? 2'b00 : 2'b11;
        if ($urandom_range(99, 0) < 85) ix = $urandom_range(NF - 1, 0);
        else ix = $urandom_range(15, NF);
        set_cmd(i, op, ix);
    endtask

    // One clock of requester behaviour: the granted requester moves on.
    task automatic step(input bit allow_new);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs_w == i) begin
                if (allow_new && $urandom_range(1, 0) == 1) new_cmd(i);
                else req_valid[i] = 1'b0;
            end else if (allow_new && !req_valid[i] && $urandom_range(9, 0) < 3) begin
                new_cmd(i);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != '0 || expq.size() != 0) && n < 60) begin
            step(1'b0);
            n++;
        end
        chk("drain_valid", 32'(req_valid), 32'(0));
        chk("drain_queue", 32'(expq.size()), 32'(0));
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_idx = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Contention straight out of reset: grants 0,1,2,3.
        for (int i = 0; i < NR; i++) set_cmd(i, 2'b10, 4 + i);
        repeat (14) step(1'b0);
        drain();

        // Directed corner cases: mismatch, illegal op, index bound.
        set_cmd(1, 2'b01, 3);
        drain();
        set_cmd(2, 2'b11, 1);
        drain();
        set_cmd(3, 2'b10, 9);
        drain();

        repeat (3000) step(1'b1);
        drain();

        // Reset while the SET pulse is on the bank.
        set_cmd(2, 2'b10, 0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (s_out == 8'h01) seen = 1'b1;
        end
        chk("reset_wait_issue", 32'(seen), 32'(1));
        #1 rst = 1'b0;
        #1;
        chk("rst_s_out", 32'(s_out), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_grant", 32'(grant_id), 32'(0));
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // rr_ptr must be back at 0, so requester 0 beats 3.
        set_cmd(3, 2'b10, 6);
        set_cmd(0, 2'b10, 7);
        repeat (8) step(1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
